// File: rtl/loop_responder.sv
// loop_responder: pops 56-bit RX words, folds each into a 34-bit reply and writes it back to TX.
// Define LOOP_RESP_STATS_EN to build the saturating reply/drop counters.
module loop_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_enable,
  input  logic        i_trx_valid,
  input  logic [55:0] i_trx_data,
  output logic        o_trx_rd,
  input  logic        i_trx_rdy,
  output logic [33:0] o_trx_data,
  output logic        o_trx_wr,
  output logic        o_busy,
  output logic        o_timeout,
  input  logic        i_cnt_clr,
  output logic [15:0] o_resp_cnt,
  output logic [15:0] o_drop_cnt
);
  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;
  localparam logic [16:0] TO = 17'(TIMEOUT_CYCLES);
  state_t state;
  logic [55:0] word;
  logic [15:0] tcnt;
  logic [16:0] tnext;
  logic [33:0] reply;
  logic expire, resp_evt, drop_evt;
  assign reply = {word[55:54], word[31:0] ^ {8'h00, word[55:32]}};
  assign tnext = {1'b0, tcnt} + 17'd1;
  // rdy is tested before expiry, so rdy arriving on the final cycle still writes
  assign expire = (TO != 17'd0) && (tnext == TO);
  assign resp_evt = (state == SEND) && i_trx_rdy;
  assign drop_evt = (state == SEND) && !i_trx_rdy && expire;
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      state      <= IDLE;
      word       <= '0;
      tcnt       <= '0;
      o_trx_rd   <= 1'b0;
      o_trx_data <= '0;
      o_trx_wr   <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_trx_rd  <= 1'b0;
      o_trx_wr  <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE:
          if (i_enable && i_trx_valid) begin
            word     <= i_trx_data;
            o_trx_rd <= 1'b1;
            tcnt     <= '0;
            o_busy   <= 1'b1;
            state    <= CALC;
          end
        CALC: begin
          o_trx_data <= reply;
          state      <= SEND;
        end
        SEND:
          if (i_trx_rdy) begin
            o_trx_wr <= 1'b1;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end else if (expire) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else
            tcnt <= tnext[15:0];
        default: state <= IDLE;
      endcase
    end
`ifdef LOOP_RESP_STATS_EN
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      o_resp_cnt <= '0;
      o_drop_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_resp_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (resp_evt && o_resp_cnt != 16'hFFFF) o_resp_cnt <= o_resp_cnt + 16'd1;
      if (drop_evt && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
`else
  logic unused_stats;
  assign unused_stats = ^{i_cnt_clr, resp_evt, drop_evt};
  assign o_resp_cnt = '0;
  assign o_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_loop_responder.sv
// tb_loop_responder: directed checks of loop_responder with TIMEOUT_CYCLES = 8.
module tb_loop_responder;
`ifdef LOOP_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [55:0] W_A = 56'hA5_0000_1234_5678;
  localparam logic [33:0] R_A = 34'h2_1291_5678;
  localparam logic [55:0] W_Z = 56'h00_0000_0000_0000;
  localparam logic [33:0] R_Z = 34'h0_0000_0000;
  localparam logic [55:0] W_F = 56'hFF_FFFF_FFFF_FFFF;
  localparam logic [33:0] R_F = 34'h3_FF00_0000;
  localparam logic [55:0] W_M = 56'h12_3456_89AB_CDEF;
  localparam logic [33:0] R_M = 34'h0_89B9_F9B9;
  localparam logic [55:0] W_S = 56'h7F_0001_0000_0001;
  localparam logic [33:0] R_S = 34'h1_007F_0000;
  logic clk = 1'b0, arst_n = 1'b0, enable = 1'b0, trx_valid = 1'b0, trx_rdy = 1'b0, cnt_clr = 1'b0;
  logic [55:0] trx_data = '0;
  logic trx_rd, trx_wr, busy, timeout;
  logic [33:0] reply;
  logic [15:0] resp_cnt, drop_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  loop_responder #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_enable(enable), .i_trx_valid(trx_valid),
    .i_trx_data(trx_data), .o_trx_rd(trx_rd), .i_trx_rdy(trx_rdy), .o_trx_data(reply),
    .o_trx_wr(trx_wr), .o_busy(busy), .o_timeout(timeout), .i_cnt_clr(cnt_clr),
    .o_resp_cnt(resp_cnt), .o_drop_cnt(drop_cnt)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    arst_n = 1'b0;
    #2;
    checks++;
    if ({trx_rd, trx_wr, busy, timeout, reply, resp_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%b busy=%b to=%b data=%h resp=%h drop=%h want all 0",
               trx_rd, trx_wr, busy, timeout, reply, resp_cnt, drop_cnt);
    end
    step;
    #2;
    arst_n = 1'b1;
    step;
    checks++;
    if ({trx_rd, trx_wr, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got rd/wr/busy=%b want 000", {trx_rd, trx_wr, busy});
    end
  endtask
  task automatic test_single;
    enable = 1'b1; trx_rdy = 1'b1; trx_data = W_A; trx_valid = 1'b1;
    step;
    checks++;
    if ({trx_rd, trx_wr, busy} !== 3'b101) begin
      errors++;
      $display("FAIL single_accept got rd/wr/busy=%b want 101", {trx_rd, trx_wr, busy});
    end
    trx_valid = 1'b0;
    step;
    checks++;
    if ({trx_rd, trx_wr, busy} !== 3'b001) begin
      errors++;
      $display("FAIL single_calc got rd/wr/busy=%b want 001", {trx_rd, trx_wr, busy});
    end
    checks++;
    if (reply !== R_A) begin
      errors++;
      $display("FAIL single_data got %h want %h", reply, R_A);
    end
    step;
    checks++;
    if ({trx_rd, trx_wr, busy} !== 3'b010) begin
      errors++;
      $display("FAIL single_wr got rd/wr/busy=%b want 010", {trx_rd, trx_wr, busy});
    end
    step;
    checks++;
    if ({trx_rd, trx_wr, busy, reply} !== {3'b000, R_A}) begin
      errors++;
      $display("FAIL single_after got rd/wr/busy=%b data=%h want 000 %h", {trx_rd, trx_wr, busy}, reply, R_A);
    end
    checks++;
    if (resp_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL single_cnt got %0d want %0d", resp_cnt, STATS ? 1 : 0);
    end
  endtask
  task automatic test_back_to_back;
    logic [55:0] words [4];
    logic [33:0] exp [4];
    int rd_t[$], wr_t[$];
    logic [33:0] got[$];
    int idx = 0;
    words = '{W_Z, W_F, W_M, W_S};
    exp = '{R_Z, R_F, R_M, R_S};
    trx_rdy = 1'b1; trx_data = words[0]; trx_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step;
      if (trx_rd) begin
        rd_t.push_back(c);
        idx++;
        trx_valid = idx < 4;
        if (idx < 4) trx_data = words[idx];
      end
      if (trx_wr) begin
        wr_t.push_back(c);
        got.push_back(reply);
      end
    end
    checks++;
    if (rd_t.size() != 4 || wr_t.size() != 4) begin
      errors++;
      $display("FAIL b2b_pulses got rd=%0d wr=%0d want 4 4", rd_t.size(), wr_t.size());
    end
    for (int i = 0; i < wr_t.size() && i < rd_t.size(); i++) begin
      checks++;
      if (got[i] !== exp[i] || wr_t[i] - rd_t[i] != 2) begin
        errors++;
        $display("FAIL b2b_word%0d got data=%h lat=%0d want %h 2", i, got[i], wr_t[i] - rd_t[i], exp[i]);
      end
      if (i > 0) begin
        checks++;
        if (rd_t[i] - rd_t[i-1] != 3) begin
          errors++;
          $display("FAIL b2b_spacing%0d got %0d want 3", i, rd_t[i] - rd_t[i-1]);
        end
      end
    end
    step;
    checks++;
    if (resp_cnt !== (STATS ? 16'd5 : 16'd0)) begin
      errors++;
      $display("FAIL b2b_cnt got %0d want %0d", resp_cnt, STATS ? 5 : 0);
    end
  endtask
  task automatic test_timeout(input bit late_rdy);
    trx_rdy = 1'b0; trx_data = W_S; trx_valid = 1'b1;
    step;
    trx_valid = 1'b0;
    step;
    for (int k = 2; k <= 8; k++) begin
      step;
      checks++;
      if ({trx_wr, timeout, busy} !== 3'b001) begin
        errors++;
        $display("FAIL to_wait%0d got wr/to/busy=%b want 001", k, {trx_wr, timeout, busy});
      end
    end
    trx_rdy = late_rdy;
    step;
    checks++;
    if ({trx_wr, timeout, busy} !== (late_rdy ? 3'b100 : 3'b010)) begin
      errors++;
      $display("FAIL to_end got wr/to/busy=%b want %b", {trx_wr, timeout, busy}, late_rdy ? 3'b100 : 3'b010);
    end
    step;
    checks++;
    if ({trx_wr, timeout, busy, reply} !== {3'b000, R_S}) begin
      errors++;
      $display("FAIL to_after got wr/to/busy=%b data=%h want 000 %h", {trx_wr, timeout, busy}, reply, R_S);
    end
    checks++;
    if ({resp_cnt, drop_cnt} !== (STATS ? {(late_rdy ? 16'd6 : 16'd5), 16'd1} : 32'd0)) begin
      errors++;
      $display("FAIL to_cnt got resp=%0d drop=%0d late_rdy=%b", resp_cnt, drop_cnt, late_rdy);
    end
  endtask
  task automatic test_enable;
    trx_rdy = 1'b1; enable = 1'b1; trx_data = W_M; trx_valid = 1'b1;
    step;
    enable = 1'b0; trx_data = W_A;
    step;
    step;
    checks++;
    if ({trx_wr, reply} !== {1'b1, R_M}) begin
      errors++;
      $display("FAIL en_inflight got wr=%b data=%h want 1 %h", trx_wr, reply, R_M);
    end
    for (int k = 0; k < 3; k++) begin
      step;
      checks++;
      if ({trx_rd, busy} !== 2'b00) begin
        errors++;
        $display("FAIL en_blocked%0d got rd/busy=%b want 00", k, {trx_rd, busy});
      end
    end
    enable = 1'b1;
    step;
    checks++;
    if (trx_rd !== 1'b1) begin
      errors++;
      $display("FAIL en_resume got rd=%b want 1", trx_rd);
    end
    trx_valid = 1'b0;
    step;
    step;
    checks++;
    if ({trx_wr, reply} !== {1'b1, R_A}) begin
      errors++;
      $display("FAIL en_second got wr=%b data=%h want 1 %h", trx_wr, reply, R_A);
    end
    step;
    checks++;
    if (resp_cnt !== (STATS ? 16'd8 : 16'd0)) begin
      errors++;
      $display("FAIL en_cnt got %0d want %0d", resp_cnt, STATS ? 8 : 0);
    end
  endtask
  task automatic test_reset_mid;
    trx_rdy = 1'b0; trx_data = W_M; trx_valid = 1'b1;
    step;
    trx_valid = 1'b0;
    step;
    step;
    arst_n = 1'b0;
    #1;
    checks++;
    if ({trx_rd, trx_wr, busy, timeout, reply, resp_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid got rd=%b wr=%b busy=%b to=%b data=%h resp=%h drop=%h want all 0",
               trx_rd, trx_wr, busy, timeout, reply, resp_cnt, drop_cnt);
    end
    trx_rdy = 1'b1;
    step;
    #2;
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++;
      if ({trx_wr, busy} !== 2'b00) begin
        errors++;
        $display("FAIL rst_release%0d got wr/busy=%b want 00", k, {trx_wr, busy});
      end
    end
  endtask
  task automatic test_counters;
    trx_rdy = 1'b1; trx_data = W_F; trx_valid = 1'b1;
    step;
    trx_valid = 1'b0;
    step;
    cnt_clr = 1'b1;
    step;
    checks++;
    if ({trx_wr, resp_cnt, drop_cnt} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL clr_vs_wr got wr=%b resp=%0d drop=%0d want 1 0 0", trx_wr, resp_cnt, drop_cnt);
    end
    cnt_clr = 1'b0;
    step;
    trx_valid = 1'b1;
    step;
    trx_valid = 1'b0;
    step;
    step;
    checks++;
    if ({trx_wr, resp_cnt} !== {1'b1, (STATS ? 16'd1 : 16'd0)}) begin
      errors++;
      $display("FAIL cnt_after_clr got wr=%b resp=%0d want 1 %0d", trx_wr, resp_cnt, STATS ? 1 : 0);
    end
    step;
`ifdef LOOP_RESP_STATS_EN
    force dut.o_resp_cnt = 16'hFFFF;
    #1;
    release dut.o_resp_cnt;
    trx_valid = 1'b1;
    step;
    trx_valid = 1'b0;
    step;
    step;
    step;
    checks++;
    if (resp_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_saturate got %h want ffff", resp_cnt);
    end
`endif
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_enable;
    test_reset_mid;
    test_counters;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/loop_responder.md
# loop_responder

Far-end responder for the transceiver loop test. It pops 56-bit test words from a transceiver's receive side, folds each into a 34-bit reply, and writes the reply into the same transceiver's transmit side. It sits on the transceiver-B side of the link, or on a remote board, and answers the initiator that drives transceiver A. Optional saturating statistics counters feed the status bank.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: consecutive cycles with `i_trx_rdy` low in SEND before the reply is dropped. Range 0..65535; 0 disables the timeout.

Ports:
- `i_clk`, in, 1: the only clock.
- `i_arst_n`, in, 1: asynchronous reset, active-low.
- `i_enable`, in, 1: allows new words to be accepted.
- `i_trx_valid`, in, 1: RX word available; data is show-ahead.
- `i_trx_data`, in, 56: RX word `w`.
- `o_trx_rd`, out, 1: one-cycle pop pulse to RX.
- `i_trx_rdy`, in, 1: TX can accept a word.
- `o_trx_data`, out, 34: reply `r`.
- `o_trx_wr`, out, 1: one-cycle write pulse to TX.
- `o_busy`, out, 1: FSM is not in IDLE.
- `o_timeout`, out, 1: one-cycle pulse when a reply is dropped.
- `i_cnt_clr`, in, 1: synchronous clear of both counters.
- `o_resp_cnt`, out, 16: replies written.
- `o_drop_cnt`, out, 16: replies dropped.

## Operation
- All outputs are registered. Every output resets to 0, and the FSM resets to IDLE.
- Reply function:
  - `r[33:32] = w[55:54]`
  - `r[31:0] = w[31:0] ^ {8'h00, w[55:32]}`
- FSM states: IDLE, CALC, SEND.
- IDLE:
  - Condition: `i_enable && i_trx_valid` at an edge.
  - Action: capture `i_trx_data` into the word register, set `o_trx_rd` to 1 for one cycle, clear the timeout counter, go to CALC.
  - Otherwise stay in IDLE.
- CALC: drive `o_trx_rd` to 0, load `o_trx_data` with `r`, go to SEND.
- SEND with `i_trx_rdy` = 1: set `o_trx_wr` to 1 for one cycle, increment `o_resp_cnt`, go to IDLE.
- SEND with `i_trx_rdy` = 0: increment the timeout counter.
  - If `TIMEOUT_CYCLES` ≠ 0 and the count reaches `TIMEOUT_CYCLES`: set `o_timeout` to 1 for one cycle, increment `o_drop_cnt`, go to IDLE.
- `o_trx_data` holds its value after the write or drop until the next CALC.
- `o_trx_wr`, `o_trx_rd` and `o_timeout` are 0 in every cycle other than the ones listed above.
- Deasserting `i_enable` does not abort a word in flight. It only blocks the next accept in IDLE.
- `o_busy` is 1 in CALC and SEND.

## Timing
- Accept at edge E0 (IDLE, valid high):
  - `o_trx_rd` is high during E0→E1.
  - `o_trx_data` is valid from E1.
  - With `i_trx_rdy` high, `o_trx_wr` is high during E2→E3.
- Latency is 2 cycles from the accept edge to the wr edge.
- Maximum throughput is 1 word per 3 cycles.
- Valid is sampled again in IDLE at E3 and not before. RX must drop or refresh valid within 2 cycles of a pop.
- If `i_trx_rdy` rises at the same edge the timeout count is reached, rdy wins: the word is written, not dropped.
- An `i_trx_valid` glitch while the FSM is not in IDLE is ignored.
- Counters saturate at 16'hFFFF. `i_cnt_clr` wins over an increment at the same edge, so that increment is lost.
- Asserting `i_arst_n` low mid-word discards the word immediately. No wr pulse follows release.

## Configuration
- Macro `LOOP_RESP_STATS_EN`.
- Defined: `o_resp_cnt`, `o_drop_cnt` and `i_cnt_clr` behave as specified above.
- Undefined: the counters are not synthesised, `o_resp_cnt` and `o_drop_cnt` are tied to 16'h0000, and `i_cnt_clr` is ignored. `o_timeout` and all handshakes are unchanged.

## Test plan
1. Single word, transform check.
   - Stimulus: enable = 1, rdy = 1; present `w` = 56'hA5_0000_1234_5678 with valid.
   - Required: one rd pulse; `o_trx_data` = 34'h2_1291_5678; wr exactly 2 cycles after the accept edge; `o_resp_cnt` = 1.
2. Back-to-back throughput.
   - Stimulus: valid held high, 4 words queued, rdy = 1.
   - Required: 4 rd and 4 wr pulses spaced exactly 3 cycles; replies in order.
3. Backpressure and timeout.
   - Stimulus: `TIMEOUT_CYCLES` = 8, rdy = 0.
   - Required: `o_timeout` pulses 8 cycles after SEND is entered; no wr; `o_drop_cnt` = 1; back in IDLE.
   - Repeat with rdy rising on the 8th cycle. Required: wr is asserted and no timeout occurs.
4. Enable and reset mid-operation.
   - Stimulus: drop enable in CALC. Required: the reply is still written and the next valid word is not popped.
   - Stimulus: reset in SEND. Required: all outputs 0 and no wr after release.
5. Counters.
   - Stimulus: preload `o_resp_cnt` to 16'hFFFF via 65535 replies, then send one more reply.
   - Required: the count stays at 16'hFFFF.
   - Stimulus: `i_cnt_clr` coincident with a wr. Required: `o_resp_cnt` = 0.
   - Stimulus: build without `LOOP_RESP_STATS_EN`. Required: both counters read 0.
